digit_serial_multiplier: RTL and testbench



---
 rtl/digit_serial_multiplier.sv | 133 +++++++++++++
 tb/tb_digit_serial_multiplier.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_multiplier.sv
// Purpose : iterative WIDTH x WIDTH multiplier, one 4-bit digit of b per clock (optional MULT_SIGNED_EN).
// Latency : N+1 cycles from the accept edge to o_out_vld (N = WIDTH/4); initiation interval N+2.
// Backpr. : o_p/o_out_vld hold in DONE until i_out_rdy; o_in_rdy is high only in IDLE.
module digit_serial_multiplier #(
  parameter int WIDTH = 12
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_vld,
  output logic               o_in_rdy,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_out_vld,
  input  logic               i_out_rdy,
  output logic [2*WIDTH-1:0] o_p
);

  localparam int N  = WIDTH / 4;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("digit_serial_multiplier: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [SW-1:0]        r_step;
  logic [2*WIDTH-1:0]   r_p;
`ifdef MULT_SIGNED_EN
  logic                 r_sign;
`endif

  logic                 w_accept;
  logic                 w_last;
  logic [3:0]           w_digit;
  logic [WIDTH+3:0]     w_partial;
  logic [2*WIDTH-1:0]   w_shifted;
  logic [2*WIDTH-1:0]   w_sum;
  logic [2*WIDTH-1:0]   w_final;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;

  assign w_accept  = (r_state == ST_IDLE) && i_in_vld;
  assign w_last    = (r_step == SW'(N - 1));
  assign o_in_rdy  = (r_state == ST_IDLE);
  assign o_out_vld = (r_state == ST_DONE);
  assign o_p       = r_p;

  // Current multiplier digit, least significant first.
  assign w_digit = 4'(r_b >> {r_step, 2'b00});

  // Partial product a x digit built from 4x4 sub-products, one per nibble of a.
  always_comb begin
    w_partial = '0;
    for (int k = 0; k < N; k++) begin
      w_partial = w_partial +
        ((WIDTH+4)'({4'b0000, r_a[4*k +: 4]} * {4'b0000, w_digit}) << (4*k));
    end
  end

  assign w_shifted = {{(WIDTH-4){1'b0}}, w_partial} << {r_step, 2'b00};
  assign w_sum     = r_acc + w_shifted;

`ifdef MULT_SIGNED_EN
  // Sign-magnitude around the unsigned core; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
  assign w_a_mag = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
  assign w_b_mag = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;
  assign w_final = r_sign ? (~w_sum + 1'b1) : w_sum;
`else
  assign w_a_mag = i_a;
  assign w_b_mag = i_b;
  assign w_final = w_sum;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode: accept in IDLE, N digit steps in BUSY, hold in DONE until drained.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_in_vld)  w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (i_out_rdy) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, accumulate one digit per BUSY cycle, load p on the last step.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_step <= '0;
      r_p    <= '0;
`ifdef MULT_SIGNED_EN
      r_sign <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a    <= w_a_mag;
      r_b    <= w_b_mag;
      r_acc  <= '0;
      r_step <= '0;
`ifdef MULT_SIGNED_EN
      r_sign <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
`endif
    end else if (r_state == ST_BUSY) begin
      r_acc <= w_sum;
      if (w_last) begin
        r_step <= '0;
        r_p    <= w_final;
      end else begin
        r_step <= r_step + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Purpose : self-checking bench for digit_serial_multiplier (WIDTH=12), optional MULT_SIGNED_EN.
// Latency : expects o_out_vld N+1 clock edges after the accept edge, counting the accept edge.
// Backpr. : exercises out_ready stalls and checks that p/out_valid hold and in_ready stays low.
module tb_digit_serial_multiplier;

  localparam int W     = 12;
  localparam int NSTEP = W / 4;

  logic           clk;
  logic           rst_n;
  logic           in_vld;
  logic           in_rdy;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_vld;
  logic           out_rdy;
  logic [2*W-1:0] p;

  int checks   = 0;
  int failures = 0;

  digit_serial_multiplier #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_in_vld  (in_vld),
    .o_in_rdy  (in_rdy),
    .i_a       (a),
    .i_b       (b),
    .o_out_vld (out_vld),
    .i_out_rdy (out_rdy),
    .o_p       (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product straight from integer arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] av, input logic [W-1:0] bv);
    longint sa;
    longint sb;
    longint pr;
`ifdef MULT_SIGNED_EN
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
`else
    sa = longint'({1'b0, av});
    sb = longint'({1'b0, bv});
`endif
    pr = sa * sb;
    return pr[2*W-1:0];
  endfunction

  // One transaction: drive, observe, and report what was seen. Starts and ends at a negedge with DUT idle.
  task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input int stall,
                        input bit scramble, input bit keep_vld,
                        output logic [2*W-1:0] p_o, output int lat, output bit hold_ok,
                        output bit rdy_ok, output bit post_ok, output bit to);
    hold_ok = 1'b1; rdy_ok = 1'b1; post_ok = 1'b1; to = 1'b0;
    if (in_rdy !== 1'b1) rdy_ok = 1'b0;
    a = a_v; b = b_v; in_vld = 1'b1; out_rdy = (stall == 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_vld = keep_vld;
    if (scramble) begin a = W'($urandom); b = W'($urandom); end
    else begin a = '0; b = '0; end
    while (out_vld !== 1'b1 && !to) begin
      if (in_rdy !== 1'b0) rdy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (scramble) begin a = W'($urandom); b = W'($urandom); end
      if (lat > 40) to = 1'b1;
    end
    p_o = p;
    for (int i = 0; i < stall; i++) begin
      if (in_rdy !== 1'b0) rdy_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (out_vld !== 1'b1 || p !== p_o) hold_ok = 1'b0;
    end
    if (in_rdy !== 1'b0) rdy_ok = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || p !== p_o) post_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (p !== '0)         begin failures++; $display("FAIL reset_p got=%h exp=0", p); end
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
    checks++; if (in_rdy !== 1'b1)  begin failures++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max_operands();
    logic [2*W-1:0] po; int lat; bit h, r, q, to;
    run_op(12'hFFF, 12'hFFF, 0, 1'b0, 1'b0, po, lat, h, r, q, to);
    checks++; if (po !== ref_mul(12'hFFF, 12'hFFF)) begin failures++; $display("FAIL max_p got=%h exp=%h", po, ref_mul(12'hFFF, 12'hFFF)); end
    checks++; if (lat !== NSTEP + 1 || to) begin failures++; $display("FAIL max_latency got=%0d exp=%0d timeout=%b", lat, NSTEP + 1, to); end
    checks++; if (!r) begin failures++; $display("FAIL max_in_rdy got=ready-high-while-busy exp=low"); end
    checks++; if (!q) begin failures++; $display("FAIL max_handshake got=out_vld=%b in_rdy=%b exp=0/1", out_vld, in_rdy); end
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] po; int lat; bit h, r, q, to;
    run_op(12'd3328, 12'd3328, 10, 1'b0, 1'b0, po, lat, h, r, q, to);
    checks++; if (po !== ref_mul(12'd3328, 12'd3328)) begin failures++; $display("FAIL bp_p got=%h exp=%h", po, ref_mul(12'd3328, 12'd3328)); end
    checks++; if (!h) begin failures++; $display("FAIL bp_hold got=unstable exp=stable"); end
    checks++; if (!r) begin failures++; $display("FAIL bp_in_rdy got=high exp=low"); end
    checks++; if (!q) begin failures++; $display("FAIL bp_release got=out_vld=%b in_rdy=%b exp=0/1", out_vld, in_rdy); end
  endtask

  task automatic test_operand_change();
    logic [2*W-1:0] po; int lat; bit h, r, q, to;
    run_op(12'h123, 12'h456, 2, 1'b0, 1'b1, po, lat, h, r, q, to);
    checks++; if (po !== ref_mul(12'h123, 12'h456)) begin failures++; $display("FAIL opchg_p got=%h exp=%h", po, ref_mul(12'h123, 12'h456)); end
    checks++; if (lat !== NSTEP + 1 || to) begin failures++; $display("FAIL opchg_latency got=%0d exp=%0d", lat, NSTEP + 1); end
    checks++; if (!h || !q) begin failures++; $display("FAIL opchg_no_reaccept got=hold=%b post=%b exp=1/1", h, q); end
  endtask

  task automatic test_reset_mid_busy();
    logic [2*W-1:0] po; int lat; bit h, r, q, to; bit quiet;
    a = 12'hABC; b = 12'hDEF; in_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (p !== '0)         begin failures++; $display("FAIL midrst_p got=%h exp=0", p); end
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL midrst_out_vld got=%b exp=0", out_vld); end
    checks++; if (in_rdy !== 1'b1)  begin failures++; $display("FAIL midrst_in_rdy got=%b exp=1", in_rdy); end
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_vld !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL midrst_no_pulse got=out_vld-pulse exp=none"); end
    run_op(12'd2, 12'd3, 0, 1'b0, 1'b0, po, lat, h, r, q, to);
    checks++; if (po !== ref_mul(12'd2, 12'd3)) begin failures++; $display("FAIL midrst_after_p got=%h exp=%h", po, ref_mul(12'd2, 12'd3)); end
  endtask

  task automatic test_zero_operand();
    logic [2*W-1:0] po; int lat; bit h, r, q, to;
    logic [W-1:0] bv;
    bv = -12'sd5;
    run_op(12'd0, bv, 1, 1'b1, 1'b0, po, lat, h, r, q, to);
    checks++; if (po !== ref_mul(12'd0, bv)) begin failures++; $display("FAIL zero_p got=%h exp=%h", po, ref_mul(12'd0, bv)); end
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    logic [2*W-1:0] po; int lat; bit h, r, q, to;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    av = 12'h800; bv = 12'h800;
    run_op(av, bv, 0, 1'b1, 1'b0, po, lat, h, r, q, to);
    checks++; if (po !== 24'h400000) begin failures++; $display("FAIL signed_minmin got=%h exp=400000", po); end
    av = 12'hFFF; bv = 12'h001;
    run_op(av, bv, 0, 1'b1, 1'b0, po, lat, h, r, q, to);
    checks++; if (po !== 24'hFFFFFF) begin failures++; $display("FAIL signed_neg1 got=%h exp=ffffff", po); end
    checks++; if (lat !== NSTEP + 1) begin failures++; $display("FAIL signed_latency got=%0d exp=%0d", lat, NSTEP + 1); end
  endtask
`endif

  task automatic test_random();
    logic [2*W-1:0] po; int lat; bit h, r, q, to;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    for (int n = 0; n < 3000; n++) begin
      av = W'($urandom);
      bv = W'($urandom);
      run_op(av, bv, int'($urandom_range(0, 3)), 1'b1, 1'($urandom), po, lat, h, r, q, to);
      checks++; if (po !== ref_mul(av, bv)) begin failures++; $display("FAIL rand_p[%0d] a=%h b=%h got=%h exp=%h", n, av, bv, po, ref_mul(av, bv)); end
      checks++; if (lat !== NSTEP + 1 || to) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", n, lat, NSTEP + 1); end
      checks++; if (!h || !r || !q) begin failures++; $display("FAIL rand_handshake[%0d] got=hold=%b rdy=%b post=%b exp=1/1/1", n, h, r, q); end
      if (to) break;
    end
  endtask

  initial begin
    test_reset();
    test_max_operands();
    test_backpressure();
    test_operand_change();
    test_reset_mid_busy();
    test_zero_operand();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
